// File: rtl/conv_ctrl_sequencer_pkg.sv
// Shared types and defaults for the convolution control sequencer.
// Holds the state and error enums, the default widths and a state helper.
package conv_ctrl_sequencer_pkg;

    localparam int DEF_CH_W   = 4;
    localparam int DEF_TILE_W = 16;
    localparam int DEF_WDOG_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_VALID_PARAM = 3'd1,
        ST_LOAD_PARAM  = 3'd2,
        ST_LOAD_KERNEL = 3'd3,
        ST_PROCESS     = 3'd4,
        ST_IRQ         = 3'd5,
        ST_ERROR       = 3'd6
    } seqState_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_PARAM = 2'd1,
        ERR_TIMEOUT   = 2'd2
    } errCode_t;

    // The watchdog only runs while the sequencer waits on the datapath.
    function automatic logic isWaitState(input seqState_t state);
        return (state == ST_LOAD_KERNEL) || (state == ST_PROCESS);
    endfunction

endpackage

// File: rtl/conv_ctrl_sequencer_if.sv
// Control/status bundle between a host controller and the sequencer.
// slave is the sequencer side, master the host side.
interface conv_ctrl_sequencer_if
    import conv_ctrl_sequencer_pkg::*;
#(
    parameter int CH_W   = DEF_CH_W,
    parameter int TILE_W = DEF_TILE_W
);
    logic              i_en;
    logic              i_flush;
    logic              i_abort;
    logic              i_param_valid;
    logic [CH_W-1:0]   i_num_ch;
    logic [TILE_W-1:0] i_num_tiles;
    logic              i_full;
    logic              i_done;
    logic              i_IRQEn;
    logic              i_IRQ_reg;
    logic              i_err_clr;

    logic              o_validate_param;
    logic              o_load_param;
    logic              o_clear_en;
    logic              o_set_IRQ;
    logic              o_set_err;
    logic              o_load_kernel;
    logic              o_next_load_kernel;
    logic              o_process;
    logic              o_next_process;
    logic              o_idle;
    logic [CH_W-1:0]   o_ch_idx;
    logic [TILE_W-1:0] o_tile_idx;
    logic [1:0]        o_err_code;

    modport slave (
        input  i_en, i_flush, i_abort, i_param_valid, i_num_ch, i_num_tiles,
               i_full, i_done, i_IRQEn, i_IRQ_reg, i_err_clr,
        output o_validate_param, o_load_param, o_clear_en, o_set_IRQ, o_set_err,
               o_load_kernel, o_next_load_kernel, o_process, o_next_process,
               o_idle, o_ch_idx, o_tile_idx, o_err_code
    );

    modport master (
        output i_en, i_flush, i_abort, i_param_valid, i_num_ch, i_num_tiles,
               i_full, i_done, i_IRQEn, i_IRQ_reg, i_err_clr,
        input  o_validate_param, o_load_param, o_clear_en, o_set_IRQ, o_set_err,
               o_load_kernel, o_next_load_kernel, o_process, o_next_process,
               o_idle, o_ch_idx, o_tile_idx, o_err_code
    );

endinterface

// File: rtl/conv_ctrl_sequencer_wdog.sv
// Saturating inactivity watchdog: counts enabled cycles since the last clear
// and flags expiry once the counter is all ones.
module conv_wdog_timer
    import conv_ctrl_sequencer_pkg::*;
#(
    parameter int WDOG_W = DEF_WDOG_W
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;
    logic              w_allOnes;

    assign w_allOnes = &r_count;
    assign o_expired = i_enable && w_allOnes;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_allOnes) begin
            r_count <= r_count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/conv_ctrl_sequencer.sv
// Job sequencer for a tiled convolution engine: walks channels and tiles,
// hands out kernel-load/process phases and raises IRQ or error strobes.
module conv_ctrl_sequencer
    import conv_ctrl_sequencer_pkg::*;
#(
    parameter int CH_W   = DEF_CH_W,
    parameter int TILE_W = DEF_TILE_W,
    parameter int WDOG_W = DEF_WDOG_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    conv_ctrl_sequencer_if.slave  bus
);

    seqState_t         r_state;
    seqState_t         w_nextState;
    errCode_t          r_errCode;
    logic [CH_W-1:0]   r_numCh;
    logic [CH_W-1:0]   r_chIdx;
    logic [TILE_W-1:0] r_numTiles;
    logic [TILE_W-1:0] r_tileIdx;

    logic w_abort;
    logic w_paramOk;
    logic w_lastTile;
    logic w_lastCh;
    logic w_jobEnd;
    logic w_wdogClear;
    logic w_wdogEnable;
    logic w_wdogExpired;
    logic w_errBadParam;
    logic w_errTimeout;
    logic w_enterValid;

    assign w_abort    = bus.i_abort && (r_state != ST_IDLE);
    assign w_paramOk  = bus.i_param_valid && (bus.i_num_ch != '0) && (bus.i_num_tiles != '0);
    assign w_lastTile = (r_tileIdx == r_numTiles - TILE_W'(1));
    assign w_lastCh   = (r_chIdx == r_numCh - CH_W'(1));
    assign w_jobEnd   = w_lastTile && w_lastCh;

    assign w_wdogClear  = (w_nextState != r_state) || bus.i_full || bus.i_done;
    assign w_wdogEnable = isWaitState(r_state);

    conv_wdog_timer #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_wdogClear),
        .i_enable  (w_wdogEnable),
        .o_expired (w_wdogExpired)
    );

    // Datapath handshakes win over the watchdog; abort and reset win over everything.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_en) w_nextState = ST_VALID_PARAM;
            end
            ST_VALID_PARAM: begin
                w_nextState = w_paramOk ? ST_LOAD_PARAM : ST_IDLE;
            end
            ST_LOAD_PARAM: begin
                w_nextState = ST_LOAD_KERNEL;
            end
            ST_LOAD_KERNEL: begin
                if (bus.i_full)         w_nextState = ST_PROCESS;
                else if (w_wdogExpired) w_nextState = ST_ERROR;
            end
            ST_PROCESS: begin
                if (bus.i_done) begin
                    if (!w_jobEnd) begin
                        if (w_lastTile) w_nextState = ST_LOAD_KERNEL;
                    end else if (bus.i_IRQEn) begin
                        w_nextState = ST_IRQ;
                    end else begin
                        w_nextState = bus.i_flush ? ST_IDLE : ST_LOAD_KERNEL;
                    end
                end else if (w_wdogExpired) begin
                    w_nextState = ST_ERROR;
                end
            end
            ST_IRQ: begin
                if (!bus.i_IRQ_reg) w_nextState = bus.i_flush ? ST_IDLE : ST_LOAD_KERNEL;
            end
            ST_ERROR: begin
                if (bus.i_err_clr) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (w_abort)    w_nextState = ST_IDLE;
        if (!i_reset_n) w_nextState = ST_IDLE;
    end

    assign w_errBadParam = i_reset_n && (r_state == ST_VALID_PARAM) && !w_paramOk && !w_abort;
    assign w_errTimeout  = i_reset_n && (r_state != ST_ERROR) && (w_nextState == ST_ERROR);
    assign w_enterValid  = (r_state != ST_VALID_PARAM) && (w_nextState == ST_VALID_PARAM);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_errCode  <= ERR_NONE;
            r_numCh    <= '0;
            r_numTiles <= '0;
            r_chIdx    <= '0;
            r_tileIdx  <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_enterValid)       r_errCode <= ERR_NONE;
            else if (w_errBadParam) r_errCode <= ERR_BAD_PARAM;
            else if (w_errTimeout)  r_errCode <= ERR_TIMEOUT;

            // Job geometry is frozen at LOAD_PARAM; later input changes are ignored.
            if (w_abort) begin
                r_chIdx   <= '0;
                r_tileIdx <= '0;
            end else if (r_state == ST_LOAD_PARAM) begin
                r_numCh    <= bus.i_num_ch;
                r_numTiles <= bus.i_num_tiles;
                r_chIdx    <= '0;
                r_tileIdx  <= '0;
            end else if ((r_state == ST_PROCESS) && bus.i_done) begin
                if (!w_lastTile) begin
                    r_tileIdx <= r_tileIdx + TILE_W'(1);
                end else if (!w_lastCh) begin
                    r_chIdx   <= r_chIdx + CH_W'(1);
                    r_tileIdx <= '0;
                end else begin
                    r_chIdx   <= '0;
                    r_tileIdx <= '0;
                end
            end
        end
    end

    // Strobes are suppressed while reset is held so an abandoned job leaves no trace.
    assign bus.o_set_err          = w_errBadParam || w_errTimeout;
    assign bus.o_set_IRQ          = i_reset_n && (r_state == ST_PROCESS) && (w_nextState == ST_IRQ);
    assign bus.o_clear_en         = i_reset_n && (r_state != ST_IDLE) && (w_nextState == ST_IDLE);
    assign bus.o_validate_param   = (w_nextState == ST_VALID_PARAM);
    assign bus.o_next_load_kernel = (w_nextState == ST_LOAD_KERNEL);
    assign bus.o_next_process     = (w_nextState == ST_PROCESS);
    assign bus.o_load_param       = (r_state == ST_LOAD_PARAM);
    assign bus.o_load_kernel      = (r_state == ST_LOAD_KERNEL);
    assign bus.o_process          = (r_state == ST_PROCESS);
    assign bus.o_idle             = (r_state == ST_IDLE);
    assign bus.o_ch_idx           = r_chIdx;
    assign bus.o_tile_idx         = r_tileIdx;
    assign bus.o_err_code         = r_errCode;

endmodule
